// File: rtl/clock_mon_pkg.sv
// Shared types and helpers for the clock period monitor.
package clock_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } mon_state_t;

  typedef struct packed {
    logic err_high;
    logic err_low;
    logic err_timeout;
  } mon_err_t;

  // Unsigned window check; the lower bound clamps at zero when tol > exp.
  function automatic logic in_tol(input logic [31:0] x,
                                  input logic [31:0] exp_v,
                                  input logic [31:0] tol);
    logic [32:0] lo_b;
    logic [32:0] hi_b;
    lo_b = (exp_v > tol) ? {1'b0, exp_v - tol} : '0;
    hi_b = {1'b0, exp_v} + {1'b0, tol};
    return ({1'b0, x} >= lo_b) && ({1'b0, x} <= hi_b);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
// An input edge shows up as a one-cycle strobe three clock edges later.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_rise;
  logic r_fall;

  // Synchronize the asynchronous input and register the edge strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_sig;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
      r_fall <= ~r_s2 & r_s3;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/clock_period_monitor.sv
// Measures high/low time and period of a square wave in clock cycles,
// checks each half against EXP_HALF +/- TOL and tracks lock/timeouts.
module clock_period_monitor
  import clock_mon_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int EXP_HALF   = 5,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] high_cycles,
  output logic [CNT_WIDTH-1:0] low_cycles,
  output logic [CNT_WIDTH-1:0] period_cycles,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 err_high,
  output logic                 err_low,
  output logic                 err_timeout,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] LOCK_LIM = CNT_WIDTH'(LOCK_COUNT);

  mon_state_t           r_state;
  mon_state_t           w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_p1;
  logic [CNT_WIDTH-1:0] r_hi;
  logic                 r_hi_ok;
  logic [CNT_WIDTH-1:0] r_good;
  logic [CNT_WIDTH-1:0] w_good_inc;
  logic                 r_locked;
  logic                 r_err_low;
  logic                 r_meas_valid;
  logic [CNT_WIDTH-1:0] r_high;
  logic [CNT_WIDTH-1:0] r_low;
  logic [CNT_WIDTH-1:0] r_period;
  logic [CNT_WIDTH-1:0] r_err_count;
  logic [CNT_WIDTH:0]   w_sum;
  logic [CNT_WIDTH-1:0] w_period_sat;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_half_ok;
  logic                 w_tmo_hit;
  logic                 w_rise_evt;
  logic                 w_fall_evt;
  logic                 w_any_err;
  mon_err_t             w_err;

  sync_edge_detect u_sync (
    .i_clk  (clock),
    .i_rst  (reset),
    .i_sig  (sig_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // The half just ending is cnt+1 cycles long (saturating).
  assign w_cnt_p1     = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);
  assign w_half_ok    = in_tol(32'(w_cnt_p1), 32'(EXP_HALF), 32'(TOL));
  assign w_tmo_hit    = (r_cnt == TO_LAST);
  assign w_sum        = {1'b0, r_hi} + {1'b0, w_cnt_p1};
  assign w_period_sat = w_sum[CNT_WIDTH] ? '1 : w_sum[CNT_WIDTH-1:0];
  assign w_good_inc   = (r_good == LOCK_LIM) ? r_good : r_good + CNT_WIDTH'(1);
  assign w_any_err    = w_err.err_high | w_err.err_timeout | r_err_low;

  // Next-state, counter and error-strobe decode; edges take priority over timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err       = '0;
    w_rise_evt  = 1'b0;
    w_fall_evt  = 1'b0;
    if (reset || !enable) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = WAIT_RISE;
          w_cnt_nxt   = '0;
        end
        WAIT_RISE: begin
          if (w_rise) begin
            w_state_nxt = MEAS_HIGH;
            w_cnt_nxt   = '0;
          end else if (w_tmo_hit) begin
            w_err.err_timeout = 1'b1;
            w_cnt_nxt         = '0;
          end else begin
            w_cnt_nxt = w_cnt_p1;
          end
        end
        MEAS_HIGH: begin
          if (w_fall) begin
            w_fall_evt     = 1'b1;
            w_err.err_high = ~w_half_ok;
            w_state_nxt    = MEAS_LOW;
            w_cnt_nxt      = '0;
          end else if (w_tmo_hit) begin
            w_err.err_timeout = 1'b1;
            w_state_nxt       = WAIT_RISE;
            w_cnt_nxt         = '0;
          end else begin
            w_cnt_nxt = w_cnt_p1;
          end
        end
        MEAS_LOW: begin
          if (w_rise) begin
            w_rise_evt    = 1'b1;
            w_err.err_low = ~w_half_ok;
            w_state_nxt   = MEAS_HIGH;
            w_cnt_nxt     = '0;
          end else if (w_tmo_hit) begin
            w_err.err_timeout = 1'b1;
            w_state_nxt       = WAIT_RISE;
            w_cnt_nxt         = '0;
          end else begin
            w_cnt_nxt = w_cnt_p1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and cycle counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latch half-period measurements and publish a full period on each rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hi         <= '0;
      r_hi_ok      <= 1'b0;
      r_high       <= '0;
      r_low        <= '0;
      r_period     <= '0;
      r_meas_valid <= 1'b0;
      r_err_low    <= 1'b0;
    end else begin
      r_meas_valid <= w_rise_evt;
      r_err_low    <= w_err.err_low;
      if (w_fall_evt) begin
        r_hi    <= w_cnt_p1;
        r_hi_ok <= w_half_ok;
      end
      if (w_rise_evt) begin
        r_high   <= r_hi;
        r_low    <= w_cnt_p1;
        r_period <= w_period_sat;
      end
    end
  end

  // Lock tracking and saturating error counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_good      <= '0;
      r_locked    <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_any_err && !(&r_err_count)) begin
        r_err_count <= r_err_count + CNT_WIDTH'(1);
      end
      if (!enable || w_err.err_high || w_err.err_timeout) begin
        r_good   <= '0;
        r_locked <= 1'b0;
      end else if (w_rise_evt) begin
        if (r_hi_ok && w_half_ok) begin
          r_good   <= w_good_inc;
          r_locked <= (w_good_inc == LOCK_LIM);
        end else begin
          r_good   <= '0;
          r_locked <= 1'b0;
        end
      end
    end
  end

  // err_high/err_timeout are decoded combinationally, so locked is masked here
  // to drop in the very cycle those pulses appear; err_low is registered
  // together with r_locked and needs no mask.
  assign locked        = r_locked & ~(w_err.err_high | w_err.err_timeout);
  assign err_high      = w_err.err_high;
  assign err_timeout   = w_err.err_timeout;
  assign err_low       = r_err_low;
  assign meas_valid    = r_meas_valid;
  assign high_cycles   = r_high;
  assign low_cycles    = r_low;
  assign period_cycles = r_period;
  assign err_count     = r_err_count;

endmodule

// File: tb/tb_clock_period_monitor.sv
// Scoreboard bench for clock_period_monitor: the stimulus pushes the
// expected measurement for each driven period; a monitor pops on meas_valid.
module tb_clock_period_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        sig_in;
  logic [15:0] high_cycles;
  logic [15:0] low_cycles;
  logic [15:0] period_cycles;
  logic        meas_valid;
  logic        locked;
  logic        err_high;
  logic        err_low;
  logic        err_timeout;
  logic [15:0] err_count;

  typedef struct {
    int hi;
    int lo;
    int per;
    bit lk;
    bit el;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_eh     = 0;
  int   n_el     = 0;
  int   n_et     = 0;

  clock_period_monitor #(
    .CNT_WIDTH  (16),
    .EXP_HALF   (5),
    .TOL        (1),
    .LOCK_COUNT (4),
    .TIMEOUT    (64)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .sig_in        (sig_in),
    .high_cycles   (high_cycles),
    .low_cycles    (low_cycles),
    .period_cycles (period_cycles),
    .meas_valid    (meas_valid),
    .locked        (locked),
    .err_high      (err_high),
    .err_low       (err_low),
    .err_timeout   (err_timeout),
    .err_count     (err_count)
  );

  always #1 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // One full period starting at a negedge; optionally queue its measurement.
  task automatic drive_period(input int hi, input int lo, input bit push,
                              input bit lk, input bit el);
    exp_t e;
    if (push) begin
      e.hi  = hi;
      e.lo  = lo;
      e.per = hi + lo;
      e.lk  = lk;
      e.el  = el;
      q.push_back(e);
    end
    sig_in = 1'b1;
    repeat (hi) @(negedge clock);
    sig_in = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_high"},   32'(high_cycles),   0);
    chk({tag, "_low"},    32'(low_cycles),    0);
    chk({tag, "_period"}, 32'(period_cycles), 0);
    chk({tag, "_mvalid"}, 32'(meas_valid),    0);
    chk({tag, "_locked"}, 32'(locked),        0);
    chk({tag, "_eh"},     32'(err_high),      0);
    chk({tag, "_el"},     32'(err_low),       0);
    chk({tag, "_et"},     32'(err_timeout),   0);
    chk({tag, "_ecount"}, 32'(err_count),     0);
  endtask

  // Monitor: count error pulses and compare each published measurement.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (err_high === 1'b1) begin
        n_eh++;
        chk("locked_at_err_high", 32'(locked), 0);
      end
      if (err_timeout === 1'b1) begin
        n_et++;
        chk("locked_at_err_timeout", 32'(locked), 0);
      end
      if (err_low === 1'b1) n_el++;
      if (meas_valid === 1'b1) begin
        chk("meas_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          chk("meas_high",   32'(high_cycles),   32'(mon_e.hi));
          chk("meas_low",    32'(low_cycles),    32'(mon_e.lo));
          chk("meas_period", 32'(period_cycles), 32'(mon_e.per));
          chk("meas_locked", 32'(locked),        32'(mon_e.lk));
          chk("meas_errlow", 32'(err_low),       32'(mon_e.el));
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    repeat (4) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    repeat (3) @(negedge clock);

    // Nominal 5/5: lock on the fourth measured period.
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 1, 0);
    drive_period(5, 5, 1, 1, 0);
    drive_period(5, 5, 1, 1, 0);
    chk("nominal_locked", 32'(locked), 1);
    chk("nominal_errcount", 32'(err_count), 0);

    // Stretched high phase, then re-lock.
    drive_period(8, 5, 1, 0, 0);
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 1, 0);
    chk("stretch_errcount", 32'(err_count), 1);
    chk("stretch_eh_pulses", 32'(n_eh), 1);

    // 4/6 inside tolerance, 3/7 outside on both halves.
    for (int i = 0; i < 5; i++) drive_period(4, 6, 1, 1, 0);
    drive_period(3, 7, 1, 0, 1);
    drive_period(3, 7, 1, 0, 1);
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 1, 0);

    // Stuck low for 200 cycles: three timeouts, partial period discarded.
    drive_period(5, 200, 0, 0, 0);
    chk("hold_locked", 32'(locked), 0);
    chk("hold_et_pulses", 32'(n_et), 3);
    chk("hold_eh_pulses", 32'(n_eh), 3);
    chk("hold_el_pulses", 32'(n_el), 2);
    chk("hold_errcount", 32'(err_count), 8);
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 1, 0);

    // Drop enable mid high phase; outputs retained, lock lost.
    sig_in = 1'b1;
    repeat (6) @(negedge clock);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    chk("dis_locked", 32'(locked), 0);
    chk("dis_high", 32'(high_cycles), 5);
    chk("dis_low", 32'(low_cycles), 5);
    chk("dis_period", 32'(period_cycles), 10);
    chk("dis_errcount", 32'(err_count), 8);
    sig_in = 1'b0;
    repeat (10) @(negedge clock);
    enable = 1'b1;
    repeat (3) @(negedge clock);
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 0, 0);
    drive_period(5, 5, 1, 1, 0);
    drive_period(5, 5, 1, 1, 0);

    // Rise strobe lands exactly on the timeout count: edge wins.
    drive_period(5, 64, 1, 0, 1);
    drive_period(5, 5, 1, 0, 0);

    // Reset in the middle of a high phase.
    sig_in = 1'b1;
    repeat (6) @(negedge clock);
    chk("edge_at_tmo_et_pulses", 32'(n_et), 3);
    chk("edge_at_tmo_el_pulses", 32'(n_el), 3);
    chk("pre_reset_errcount", 32'(err_count), 9);
    chk("pre_reset_queue_drained", 32'(q.size()), 0);
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("midreset");
    reset  = 1'b0;
    sig_in = 1'b0;
    repeat (5) @(negedge clock);
    chk("final_queue_drained", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
